// File: rtl/pwm_multi.sv
// pwm_multi: NCH-channel PWM generator sharing one prescaled timebase.
// The timebase counts edge-aligned (sawtooth) or center-aligned (triangle).
// Period, mode and per-channel duty are double-buffered: writes land in
// shadow registers and reach the active registers only at a period boundary,
// so a running waveform never glitches. While the block is disabled the
// actives follow the shadows directly.
module pwm_multi #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int PRE_W = 8,
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             center_mode,
   input  logic [WIDTH-1:0] period,
   input  logic [PRE_W-1:0] prescale,
   input  logic             duty_wr,
   input  logic [CH_W-1:0]  duty_ch,
   input  logic [WIDTH-1:0] duty_val,
   input  logic [NCH-1:0]   ch_en,
   output logic [NCH-1:0]   pwm_out,
   output logic             period_tick,
   output logic [WIDTH-1:0] count
);

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

   logic [PRE_W-1:0] pre_cnt;
   logic             tick;
   logic             boundary;

   dir_t             dir;
   dir_t             dir_next;
   logic [WIDTH-1:0] count_next;

   logic [WIDTH-1:0] period_sh;
   logic [WIDTH-1:0] period_act;
   logic             mode_sh;
   logic             mode_act;
   logic [WIDTH-1:0] duty_sh   [NCH];
   logic [WIDTH-1:0] duty_next [NCH];
   logic [WIDTH-1:0] duty_act  [NCH];
   logic [NCH-1:0]   pwm_next;

   // Timebase advances one step on every (prescale+1)-th enabled clock.
   assign tick = enable && (pre_cnt == prescale);

   // A boundary is the tick on which the timebase lands on 0; with a zero
   // period the count never leaves 0, so every tick qualifies.
   assign boundary = tick && (count_next == '0);

   // Prescaler: free-running 0..prescale while enabled, parked at 0 otherwise.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_cnt <= '0;
      end else if (!enable || tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // Timebase state register: count and counting direction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         dir   <= DIR_UP;
      end else if (!enable) begin
         count <= '0;
         dir   <= DIR_UP;
      end else if (tick) begin
         count <= count_next;
         dir   <= dir_next;
      end
   end

   // Timebase next-state: sawtooth in edge mode, triangle in center mode.
   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      count_next = count;
      dir_next   = dir;
      if (!mode_act) begin
         count_next = (count == period_act) ? '0 : count + WIDTH'(1);
         dir_next   = DIR_UP;
      end else if (dir == DIR_UP) begin
         if (count == period_act) begin
            count_next = (period_act == '0) ? '0 : count - WIDTH'(1);
            dir_next   = DIR_DOWN;
         end else begin
            count_next = count + WIDTH'(1);
         end
      end else begin
         count_next = count - WIDTH'(1);
      end
      // Reaching 0 always restarts the climb, which also makes a mode switch
      // at a boundary start the new period counting up.
      if (count_next == '0) begin
         dir_next = DIR_UP;
      end
   end

   // Duty shadow next-value: a write to an out-of-range channel matches no
   // index and is dropped. Loading actives from this value lets a write in
   // the boundary clock take effect for the period that is just starting.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         duty_next[i] = duty_sh[i];
         if (duty_wr && (duty_ch == CH_W'(i))) begin
            duty_next[i] = duty_val;
         end
      end
   end

   // Shadow registers: period and mode track their inputs every clock.
   // NOTE: the duty shadow array is a small register file, not a RAM, so it
   // is cleared by reset like every other flop in the block.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_sh <= '0;
         mode_sh   <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            duty_sh[i] <= '0;
         end
      end else begin
         period_sh <= period;
         mode_sh   <= center_mode;
         for (int i = 0; i < NCH; i++) begin
            duty_sh[i] <= duty_next[i];
         end
      end
   end

   // Active registers: reload at a boundary, or continuously while disabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_act <= '0;
         mode_act   <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            duty_act[i] <= '0;
         end
      end else if (!enable || boundary) begin
         period_act <= period_sh;
         mode_act   <= mode_sh;
         for (int i = 0; i < NCH; i++) begin
            duty_act[i] <= duty_next[i];
         end
      end
   end

   // Output decode: a channel is high while the timebase is below its duty.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         pwm_next[i] = enable && ch_en[i] && (count < duty_act[i]);
      end
   end

   // Registered outputs keep the pins free of comparator glitches.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_out     <= '0;
         period_tick <= 1'b0;
      end else begin
         pwm_out     <= pwm_next;
         period_tick <= boundary;
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: self-checking bench for pwm_multi.
// The reference model tracks each period as a phase index 0..L-1, where
// L = period+1 (edge), 2*period (center) or 1 (period 0); the count is a
// closed-form function of the phase. Directed scenarios add duty/tick counts
// derived by hand from the waveform rules.
module tb_pwm_multi;

   localparam int WIDTH = 8;
   localparam int NCH   = 3;
   localparam int PRE_W = 8;
   localparam int CH_W  = 2;

   logic             clk         = 1'b0;
   logic             reset       = 1'b0;
   logic             enable      = 1'b0;
   logic             center_mode = 1'b0;
   logic [WIDTH-1:0] period      = '0;
   logic [PRE_W-1:0] prescale    = '0;
   logic             duty_wr     = 1'b0;
   logic [CH_W-1:0]  duty_ch     = '0;
   logic [WIDTH-1:0] duty_val    = '0;
   logic [NCH-1:0]   ch_en       = '0;
   logic [NCH-1:0]   pwm_out;
   logic             period_tick;
   logic [WIDTH-1:0] count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pwm_multi #(.WIDTH(WIDTH), .NCH(NCH), .PRE_W(PRE_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .center_mode(center_mode),
      .period     (period),
      .prescale   (prescale),
      .duty_wr    (duty_wr),
      .duty_ch    (duty_ch),
      .duty_val   (duty_val),
      .ch_en      (ch_en),
      .pwm_out    (pwm_out),
      .period_tick(period_tick),
      .count      (count)
   );

   // ---------------- reference model ----------------
   int               m_pre, m_phase, m_per_act, m_per_sh;
   bit               m_mode_act, m_mode_sh;
   int               m_duty_act [NCH];
   int               m_duty_sh  [NCH];
   logic [NCH-1:0]   exp_pwm   = '0;
   logic             exp_tick  = 1'b0;
   logic [WIDTH-1:0] exp_count = '0;

   function automatic int per_len(int p, bit m);
      if (p == 0) return 1;
      return m ? 2 * p : p + 1;
   endfunction

   function automatic int phase_to_count(int ph, int p, bit m);
      return (m && ph > p) ? 2 * p - ph : ph;
   endfunction

   initial begin : model
      int cur;
      int dnew [NCH];
      bit b;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_pre = 0; m_phase = 0; m_per_act = 0; m_per_sh = 0;
            m_mode_act = 0; m_mode_sh = 0;
            for (int i = 0; i < NCH; i++) begin
               m_duty_act[i] = 0; m_duty_sh[i] = 0;
            end
            exp_pwm = '0; exp_tick = 1'b0; exp_count = '0;
         end else begin
            cur = phase_to_count(m_phase, m_per_act, m_mode_act);
            for (int i = 0; i < NCH; i++) begin
               dnew[i] = (duty_wr && int'(duty_ch) == i) ? int'(duty_val) : m_duty_sh[i];
               exp_pwm[i] = enable && ch_en[i] && (cur < m_duty_act[i]);
            end
            b = 0;
            if (!enable) begin
               m_pre = 0; m_phase = 0; b = 1;
            end else if (m_pre == int'(prescale)) begin
               m_pre = 0;
               m_phase = (m_phase + 1) % per_len(m_per_act, m_mode_act);
               b = (m_phase == 0);
            end else begin
               m_pre++;
            end
            if (b) begin
               m_per_act = m_per_sh; m_mode_act = m_mode_sh;
               for (int i = 0; i < NCH; i++) m_duty_act[i] = dnew[i];
            end
            exp_tick  = b && enable;
            m_per_sh  = int'(period);
            m_mode_sh = center_mode;
            for (int i = 0; i < NCH; i++) m_duty_sh[i] = dnew[i];
            exp_count = WIDTH'(phase_to_count(m_phase, m_per_act, m_mode_act));
         end
      end
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic configure(input logic [WIDTH-1:0] p, input logic m,
                            input logic [PRE_W-1:0] pre, input logic [NCH-1:0] en);
      @(negedge clk);
      enable = 1'b0; duty_wr = 1'b0;
      period = p; center_mode = m; prescale = pre; ch_en = en;
      repeat (3) @(negedge clk);
   endtask

   task automatic wr_duty(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] v);
      duty_wr = 1'b1; duty_ch = ch; duty_val = v;
      @(negedge clk);
      duty_wr = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) begin
         @(negedge clk);
         n_cmp++;
         if ({count, period_tick, pwm_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_state got cnt=%0d tick=%b pwm=%b want all 0", count, period_tick, pwm_out);
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_edge();
      int highs = 0, ticks = 0;
      configure(8'd9, 1'b0, 8'd0, 3'b001);
      wr_duty(2'd0, 8'd3);
      enable = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({count, period_tick, pwm_out} !== {exp_count, exp_tick, exp_pwm}) begin
            n_bad++;
            $display("FAIL edge t=%0t got cnt=%0d tick=%b pwm=%b want cnt=%0d tick=%b pwm=%b",
                     $time, count, period_tick, pwm_out, exp_count, exp_tick, exp_pwm);
         end
         if (c >= 10) begin highs += int'(pwm_out[0]); ticks += int'(period_tick); end
      end
      n_cmp++;
      if (highs != 6 || ticks != 2) begin
         n_bad++;
         $display("FAIL edge_duty got highs=%0d ticks=%0d want highs=6 ticks=2", highs, ticks);
      end
   endtask

   task automatic test_center();
      int highs = 0, ticks = 0;
      configure(8'd4, 1'b1, 8'd0, 3'b010);
      wr_duty(2'd1, 8'd2);
      enable = 1'b1;
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({count, period_tick, pwm_out} !== {exp_count, exp_tick, exp_pwm}) begin
            n_bad++;
            $display("FAIL center t=%0t got cnt=%0d tick=%b pwm=%b want cnt=%0d tick=%b pwm=%b",
                     $time, count, period_tick, pwm_out, exp_count, exp_tick, exp_pwm);
         end
         if (c >= 10) begin highs += int'(pwm_out[1]); ticks += int'(period_tick); end
      end
      n_cmp++;
      if (highs != 6 || ticks != 2) begin
         n_bad++;
         $display("FAIL center_duty got highs=%0d ticks=%0d want highs=6 ticks=2", highs, ticks);
      end
   endtask

   task automatic test_prescale();
      int highs = 0, ticks = 0;
      configure(8'd3, 1'b0, 8'd2, 3'b001);
      wr_duty(2'd0, 8'd2);
      enable = 1'b1;
      for (int c = 0; c < 34; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({count, period_tick, pwm_out} !== {exp_count, exp_tick, exp_pwm}) begin
            n_bad++;
            $display("FAIL prescale t=%0t got cnt=%0d tick=%b pwm=%b want cnt=%0d tick=%b pwm=%b",
                     $time, count, period_tick, pwm_out, exp_count, exp_tick, exp_pwm);
         end
         if (c >= 10) begin highs += int'(pwm_out[0]); ticks += int'(period_tick); end
      end
      n_cmp++;
      if (highs != 12 || ticks != 2) begin
         n_bad++;
         $display("FAIL prescale_duty got highs=%0d ticks=%0d want highs=12 ticks=2", highs, ticks);
      end
   endtask

   task automatic test_shadow();
      int  highs;
      bit  found;
      configure(8'd9, 1'b0, 8'd0, 3'b001);
      wr_duty(2'd0, 8'd3);
      enable = 1'b1;
      // write duty 7 mid-period: the running period must keep duty 3
      found = 0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(negedge clk);
         found = (count == 8'd5);
      end
      n_cmp++;
      if (!found) begin n_bad++; $display("FAIL shadow_wait5 got no count=5 within 30 clocks want count=5"); end
      duty_wr = 1'b1; duty_ch = 2'd0; duty_val = 8'd7;
      highs = 0; found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         duty_wr = 1'b0;
         n_cmp++;
         if ({count, period_tick, pwm_out} !== {exp_count, exp_tick, exp_pwm}) begin
            n_bad++;
            $display("FAIL shadow t=%0t got cnt=%0d tick=%b pwm=%b want cnt=%0d tick=%b pwm=%b",
                     $time, count, period_tick, pwm_out, exp_count, exp_tick, exp_pwm);
         end
         highs += int'(pwm_out[0]);
         found = period_tick;
      end
      n_cmp++;
      if (!found || highs != 0) begin
         n_bad++;
         $display("FAIL shadow_hold got tick_seen=%0d highs=%0d want tick_seen=1 highs=0", found, highs);
      end
      highs = 0;
      repeat (10) begin @(negedge clk); highs += int'(pwm_out[0]); end
      n_cmp++;
      if (highs != 7) begin n_bad++; $display("FAIL shadow_next got highs=%0d want 7", highs); end
      // write duty 5 in the boundary clock: applies to the period it opens
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         found = (count == 8'd9);
      end
      duty_wr = 1'b1; duty_val = 8'd5;
      @(negedge clk);
      duty_wr = 1'b0;
      n_cmp++;
      if (!found || period_tick !== 1'b1) begin
         n_bad++;
         $display("FAIL shadow_bwait got found=%0d tick=%b want found=1 tick=1", found, period_tick);
      end
      highs = 0;
      repeat (10) begin @(negedge clk); highs += int'(pwm_out[0]); end
      n_cmp++;
      if (highs != 5) begin n_bad++; $display("FAIL shadow_at_b got highs=%0d want 5", highs); end
   endtask

   task automatic test_limits();
      int h0 = 0, h1 = 0, h2 = 0, ticks = 0;
      configure(8'd9, 1'b0, 8'd0, 3'b111);
      wr_duty(2'd0, 8'd0);
      wr_duty(2'd1, 8'd10);
      wr_duty(2'd2, 8'd5);
      enable = 1'b1;
      wr_duty(2'd3, 8'd1);          // out-of-range channel, must be ignored
      for (int c = 0; c < 60; c++) begin
         if (c == 40) ch_en = 3'b011;
         @(negedge clk);
         n_cmp++;
         if ({count, period_tick, pwm_out} !== {exp_count, exp_tick, exp_pwm}) begin
            n_bad++;
            $display("FAIL limits t=%0t got cnt=%0d tick=%b pwm=%b want cnt=%0d tick=%b pwm=%b",
                     $time, count, period_tick, pwm_out, exp_count, exp_tick, exp_pwm);
         end
         h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]);
         if (c >= 20 && c < 30) h2 += int'(pwm_out[2]);
         if (c >= 41) h2 += int'(pwm_out[2]);
         if (c >= 40) ticks += int'(period_tick);
      end
      n_cmp++;
      if (h0 != 0 || h1 != 60 || h2 != 5 || ticks != 2) begin
         n_bad++;
         $display("FAIL limits_sum got h0=%0d h1=%0d h2=%0d ticks=%0d want h0=0 h1=60 h2=5 ticks=2",
                  h0, h1, h2, ticks);
      end
   endtask

   task automatic test_enable_reset();
      int  n;
      bit  found;
      configure(8'd9, 1'b0, 8'd0, 3'b001);
      wr_duty(2'd0, 8'd3);
      enable = 1'b1;
      repeat (12) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({count, period_tick, pwm_out} !== '0) begin
         n_bad++;
         $display("FAIL disable got cnt=%0d tick=%b pwm=%b want all 0", count, period_tick, pwm_out);
      end
      enable = 1'b1;
      repeat (13) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({count, period_tick, pwm_out} !== '0) begin
         n_bad++;
         $display("FAIL async_reset got cnt=%0d tick=%b pwm=%b want all 0", count, period_tick, pwm_out);
      end
      enable = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      configure(8'd9, 1'b0, 8'd0, 3'b001);
      wr_duty(2'd0, 8'd3);
      enable = 1'b1;
      n = 0; found = 0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(negedge clk);
         n++;
         n_cmp++;
         if ({count, period_tick, pwm_out} !== {exp_count, exp_tick, exp_pwm}) begin
            n_bad++;
            $display("FAIL restart t=%0t got cnt=%0d tick=%b pwm=%b want cnt=%0d tick=%b pwm=%b",
                     $time, count, period_tick, pwm_out, exp_count, exp_tick, exp_pwm);
         end
         found = period_tick;
      end
      n_cmp++;
      if (!found || n != 10) begin
         n_bad++;
         $display("FAIL first_tick got clocks=%0d seen=%0d want clocks=10 seen=1", n, found);
      end
   endtask

   task automatic test_random();
      for (int s = 0; s < 6; s++) begin
         configure(WIDTH'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                   PRE_W'($urandom_range(0, 3)), NCH'($urandom_range(0, 7)));
         for (int i = 0; i < NCH; i++) wr_duty(CH_W'(i), WIDTH'($urandom_range(0, 14)));
         enable = 1'b1;
         for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({count, period_tick, pwm_out} !== {exp_count, exp_tick, exp_pwm}) begin
               n_bad++;
               $display("FAIL random s=%0d t=%0t got cnt=%0d tick=%b pwm=%b want cnt=%0d tick=%b pwm=%b",
                        s, $time, count, period_tick, pwm_out, exp_count, exp_tick, exp_pwm);
            end
            duty_wr  = ($urandom_range(0, 7) == 0);
            duty_ch  = CH_W'($urandom_range(0, 3));
            duty_val = WIDTH'($urandom_range(0, 14));
            if ($urandom_range(0, 39) == 0) period = WIDTH'($urandom_range(0, 12));
            if ($urandom_range(0, 39) == 0) center_mode = ~center_mode;
            if ($urandom_range(0, 29) == 0) ch_en = NCH'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) enable = ~enable;
         end
         duty_wr = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_edge();
      test_center();
      test_prescale();
      test_shadow();
      test_limits();
      test_enable_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
